ascii_coord_parser: RTL and testbench
=====================================

ASCII_COORD_PARSER -- requirements
Module: ascii_coord_parser

Interface
REQ-001 SHALL have parameter NUM_COORDS, default 3, number of coordinate fields per frame (1..8).
REQ-002 SHALL have parameter COORD_W, default 10, bit width of each coordinate.
REQ-003 SHALL have parameter MAX_DIGITS, default 4, maximum decimal digits per field.
REQ-004 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port ascii  input  8  incoming character.
REQ-007 SHALL have port ascii_valid  input  1  character strobe, ascii sampled only when high.
REQ-008 SHALL have port coords  output  NUM_COORDS*COORD_W  last good frame, field 0 in LSBs.
REQ-009 SHALL have port coords_valid  output  1  one-cycle pulse, new frame in coords.
REQ-010 SHALL have port coords_sat  output  1  valid with coords_valid; some field saturated.
REQ-011 SHALL have port frame_error  output  1  one-cycle pulse, malformed frame dropped.
REQ-012 SHALL have port busy  output  1  high while a frame is open (state not IDLE).

Function
REQ-013 SHALL accept frame grammar: 'S' field (',' field) x (NUM_COORDS-1) 'E'; field = 1..MAX_DIGITS digits '0'..'9'.
REQ-014 SHALL ignore space, CR, LF in every state; no state change when ascii_valid is low.
REQ-015 SHALL implement states IDLE, FIELD_START (expect first digit), FIELD (accumulating); IDLE ignores all characters except 'S'.
REQ-016 'S' in IDLE -> FIELD_START, field index 0, accumulator cleared, sat flag cleared.
REQ-017 Digit in FIELD_START/FIELD -> accumulator = acc*10 + digit, digit count +1, state FIELD.
REQ-018 Accumulator SHALL saturate at 2^COORD_W-1 (unsigned) and set the frame sat flag; no wrap-around.
REQ-019 ',' in FIELD with index < NUM_COORDS-1 -> store field, index +1, FIELD_START.
REQ-020 'E' in FIELD with index = NUM_COORDS-1 -> store field, update coords, pulse coords_valid and coords_sat (if set) on the next cycle, IDLE.
REQ-021 Errors -> frame_error pulse next cycle, coords unchanged, IDLE: ',' or 'E' in FIELD_START; ',' at last field; 'E' before last field; digit count exceeding MAX_DIGITS; any other character inside a frame.
REQ-022 'S' while busy SHALL pulse frame_error and restart a new frame (FIELD_START, index 0) in the same cycle.
REQ-023 coords SHALL update atomically only on a good frame; partial fields are held in a shadow register.
REQ-024 coords_valid and frame_error SHALL never assert in the same cycle.

Reset
REQ-025 Reset SHALL force IDLE, coords=0, coords_valid=0, coords_sat=0, frame_error=0, busy=0, shadow/accumulator=0, immediately and asynchronously.
REQ-026 Reset mid-frame SHALL discard the partial frame without any pulse.

Configuration
REQ-027 Macro COORD_SIGN_EN defined: '-' accepted as first character of a field in FIELD_START; field output two's complement; saturation to +(2^(COORD_W-1)-1) / -(2^(COORD_W-1)); '-' not counted as a digit; '-' followed by ',' or 'E' is an error.
REQ-028 Macro undefined: '-' inside a frame is an error per REQ-021; fields unsigned.

Structure
REQ-029 Package ascii_coord_pkg SHALL hold ASCII constants (S, E, comma, minus, space, CR, LF, '0', '9') and the state enum.
REQ-030 Sub-module ascii_char_class SHALL combinationally classify ascii into START/END/SEP/DIGIT/MINUS/SPACE/OTHER plus 4-bit digit value.

Verification (NUM_COORDS=3, COORD_W=10, MAX_DIGITS=4)
REQ-031 "S12,345,7E" -> coords_valid one cycle after 'E', coords fields {0:12, 1:345, 2:7}, coords_sat=0.
REQ-032 "S1,2E" -> frame_error pulse one cycle after 'E', coords unchanged, busy low after.
REQ-033 "S9,2000,5E" -> coords_valid, field1=1023, coords_sat=1; "S12345,0,0E" -> frame_error on fifth digit.
REQ-034 "S1,2S3,4,5E" -> frame_error on second 'S', then coords_valid with {3,4,5}.
REQ-035 "S12," then reset, then "4,5E" -> no pulses, coords=0, busy=0.
REQ-036 "S-5,0,-512E" -> with COORD_SIGN_EN field0=0x3FB, field2=0x200; without -> frame_error at first '-'.

Source files
------------

// File: rtl/ascii_coord_pkg.sv
// ascii_coord_pkg
// Shared definitions for the ASCII coordinate frame parser: character
// constants, the parser state enum and the character class enum.
// Used by: ascii_char_class, ascii_coord_parser.
package ascii_coord_pkg;

    localparam logic [7:0] ASC_S     = 8'h53;
    localparam logic [7:0] ASC_E     = 8'h45;
    localparam logic [7:0] ASC_COMMA = 8'h2C;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_9     = 8'h39;

    typedef enum logic [1:0] {
        IDLE,
        FIELD_START,
        FIELD
    } parse_state_t;

    typedef enum logic [2:0] {
        CC_START,
        CC_END,
        CC_SEP,
        CC_DIGIT,
        CC_MINUS,
        CC_SPACE,
        CC_OTHER
    } char_class_t;

endpackage

// File: rtl/ascii_char_class.sv
// ascii_char_class
// Purely combinational classifier for one incoming character.
// Ports:
//   ascii       in  8  character to classify
//   class_c     out    START/END/SEP/DIGIT/MINUS/SPACE/OTHER
//   digit_c     out 4  decimal value when class_c is CC_DIGIT, else 0
import ascii_coord_pkg::*;

module ascii_char_class (
    input  logic [7:0]  ascii,
    output char_class_t class_c,
    output logic [3:0]  digit_c
);

    always_comb begin
        class_c = CC_OTHER;
        digit_c = 4'd0;
        if (ascii >= ASC_0 && ascii <= ASC_9) begin
            class_c = CC_DIGIT;
            // '0'..'9' are 0x30..0x39, so the low nibble is the value
            digit_c = ascii[3:0];
        end else begin
            case (ascii)
                ASC_S:                     class_c = CC_START;
                ASC_E:                     class_c = CC_END;
                ASC_COMMA:                 class_c = CC_SEP;
                ASC_MINUS:                 class_c = CC_MINUS;
                ASC_SPACE, ASC_CR, ASC_LF: class_c = CC_SPACE;
                default:                   class_c = CC_OTHER;
            endcase
        end
    end

endmodule

// File: rtl/ascii_coord_parser.sv
// ascii_coord_parser
// Parses frames of the form  S f0,f1,...,f(N-1) E  (decimal fields) from a
// character stream and publishes all fields atomically on a good frame.
// Whitespace (space/CR/LF) is ignored everywhere; malformed frames are
// dropped with a one-cycle frame_error pulse.
// Optional feature: define COORD_SIGN_EN to accept a leading '-' per field
// and produce two's-complement fields with signed saturation.
// Ports:
//   clock         in   single clock, rising edge
//   reset         in   asynchronous active-high reset
//   ascii         in   8-bit incoming character
//   ascii_valid   in   character strobe
//   coords        out  NUM_COORDS*COORD_W, last good frame, field 0 in LSBs
//   coords_valid  out  one-cycle pulse, new frame on coords
//   coords_sat    out  with coords_valid, some field saturated
//   frame_error   out  one-cycle pulse, malformed frame dropped
//   busy          out  a frame is open
import ascii_coord_pkg::*;

module ascii_coord_parser #(
    parameter int unsigned NUM_COORDS = 3,
    parameter int unsigned COORD_W    = 10,
    parameter int unsigned MAX_DIGITS = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    ascii,
    input  logic                          ascii_valid,
    output logic [NUM_COORDS*COORD_W-1:0] coords,
    output logic                          coords_valid,
    output logic                          coords_sat,
    output logic                          frame_error,
    output logic                          busy
);

    localparam int unsigned FRAME_W = NUM_COORDS * COORD_W;
    // acc*10+9 always fits in four extra bits
    localparam int unsigned ACC_W   = COORD_W + 4;
    localparam int unsigned IDX_W   = (NUM_COORDS > 1) ? $clog2(NUM_COORDS) : 1;
    localparam int unsigned CNT_W   = $clog2(MAX_DIGITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COORDS - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_DIGITS);
`ifdef COORD_SIGN_EN
    localparam logic [ACC_W-1:0] LIM_POS = {5'd0, {(COORD_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] LIM_NEG = {4'd0, 1'b1, {(COORD_W-1){1'b0}}};
`else
    localparam logic [ACC_W-1:0] LIM_U   = {4'd0, {COORD_W{1'b1}}};
`endif

    char_class_t  char_class;
    logic [3:0]   digit;

    parse_state_t state, state_next;
    logic [COORD_W-1:0] acc, acc_next;
    logic [CNT_W-1:0]   dcnt, dcnt_next;
    logic [IDX_W-1:0]   idx, idx_next;
    logic               sat, sat_next;
    logic [FRAME_W-1:0] shadow, shadow_next;
    logic [FRAME_W-1:0] coords_next;
    logic               valid_next, sat_out_next, err_next;
`ifdef COORD_SIGN_EN
    logic               neg, neg_next;
`endif

    logic [ACC_W-1:0]   prod;
    logic [ACC_W-1:0]   limit;
    logic [COORD_W-1:0] field_val;
    logic               do_start, do_digit, do_sep, do_end, go_error;

    ascii_char_class u_class (
        .ascii   (ascii),
        .class_c (char_class),
        .digit_c (digit)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state, datapath next values and output pulses
    always_comb begin
        state_next   = state;
        acc_next     = acc;
        dcnt_next    = dcnt;
        idx_next     = idx;
        sat_next     = sat;
        shadow_next  = shadow;
        coords_next  = coords;
        valid_next   = 1'b0;
        sat_out_next = 1'b0;
        err_next     = 1'b0;
        do_start     = 1'b0;
        do_digit     = 1'b0;
        do_sep       = 1'b0;
        do_end       = 1'b0;
        go_error     = 1'b0;
`ifdef COORD_SIGN_EN
        neg_next     = neg;
        limit        = neg ? LIM_NEG : LIM_POS;
        field_val    = neg ? (~acc + COORD_W'(1)) : acc;
`else
        limit        = LIM_U;
        field_val    = acc;
`endif
        prod = (ACC_W'(acc) << 3) + (ACC_W'(acc) << 1) + ACC_W'(digit);

        // Classify the strobed character against the current state
        if (ascii_valid) begin
            if (state == IDLE) begin
                do_start = (char_class == CC_START);
            end else begin
                case (char_class)
                    CC_SPACE: ;
                    CC_START: begin
                        do_start = 1'b1;
                        err_next = 1'b1;
                    end
                    CC_DIGIT: do_digit = 1'b1;
                    CC_SEP: begin
                        if (state == FIELD && idx != LAST_IDX) do_sep = 1'b1;
                        else                                   go_error = 1'b1;
                    end
                    CC_END: begin
                        if (state == FIELD && idx == LAST_IDX) do_end = 1'b1;
                        else                                   go_error = 1'b1;
                    end
`ifdef COORD_SIGN_EN
                    CC_MINUS: begin
                        // only one sign, only before the first digit
                        if (state == FIELD_START && !neg) neg_next = 1'b1;
                        else                              go_error = 1'b1;
                    end
`endif
                    default: go_error = 1'b1;
                endcase
            end
        end

        if (do_digit && dcnt == MAX_CNT) begin
            go_error = 1'b1;
            do_digit = 1'b0;
        end

        if (do_start) begin
            state_next  = FIELD_START;
            acc_next    = '0;
            dcnt_next   = '0;
            idx_next    = '0;
            sat_next    = 1'b0;
            shadow_next = '0;
`ifdef COORD_SIGN_EN
            neg_next    = 1'b0;
`endif
        end

        // Saturating accumulate: once clamped, acc*10 exceeds limit again
        if (do_digit) begin
            state_next = FIELD;
            dcnt_next  = dcnt + CNT_W'(1);
            if (prod > limit) begin
                acc_next = COORD_W'(limit);
                sat_next = 1'b1;
            end else begin
                acc_next = COORD_W'(prod);
            end
        end

        if (do_sep) begin
            shadow_next[int'(idx)*COORD_W +: COORD_W] = field_val;
            idx_next   = idx + IDX_W'(1);
            acc_next   = '0;
            dcnt_next  = '0;
            state_next = FIELD_START;
`ifdef COORD_SIGN_EN
            neg_next   = 1'b0;
`endif
        end

        if (do_end) begin
            coords_next = shadow;
            coords_next[int'(LAST_IDX)*COORD_W +: COORD_W] = field_val;
            valid_next   = 1'b1;
            sat_out_next = sat;
            state_next   = IDLE;
        end

        if (go_error) begin
            err_next   = 1'b1;
            state_next = IDLE;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc          <= '0;
            dcnt         <= '0;
            idx          <= '0;
            sat          <= 1'b0;
            shadow       <= '0;
            coords       <= '0;
            coords_valid <= 1'b0;
            coords_sat   <= 1'b0;
            frame_error  <= 1'b0;
            busy         <= 1'b0;
`ifdef COORD_SIGN_EN
            neg          <= 1'b0;
`endif
        end else begin
            acc          <= acc_next;
            dcnt         <= dcnt_next;
            idx          <= idx_next;
            sat          <= sat_next;
            shadow       <= shadow_next;
            coords       <= coords_next;
            coords_valid <= valid_next;
            coords_sat   <= sat_out_next;
            frame_error  <= err_next;
            busy         <= (state_next != IDLE);
`ifdef COORD_SIGN_EN
            neg          <= neg_next;
`endif
        end
    end

endmodule

// File: tb/tb_ascii_coord_parser.sv
// tb_ascii_coord_parser
// Scoreboard bench: each frame's expected pulse is queued when its trigger
// character is driven and compared when the DUT pulses.
module tb_ascii_coord_parser;

    localparam int unsigned NC = 3;
    localparam int unsigned CW = 10;
    localparam int unsigned MD = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [7:0]        ascii;
    logic              ascii_valid;
    logic [NC*CW-1:0]  coords;
    logic              coords_valid;
    logic              coords_sat;
    logic              frame_error;
    logic              busy;

    typedef struct {
        bit          is_err;
        logic [29:0] coords;
        bit          sat;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    ascii_coord_parser #(.NUM_COORDS(NC), .COORD_W(CW), .MAX_DIGITS(MD)) dut (
        .clock        (clock),
        .reset        (reset),
        .ascii        (ascii),
        .ascii_valid  (ascii_valid),
        .coords       (coords),
        .coords_valid (coords_valid),
        .coords_sat   (coords_sat),
        .frame_error  (frame_error),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] pack3(input int f0, input int f1, input int f2);
        logic [9:0] a, b, c;
        a = 10'(f0);
        b = 10'(f1);
        c = 10'(f2);
        return {c, b, a};
    endfunction

    // Pulse monitor / scoreboard
    always @(negedge clock) begin
        if (!reset) begin
            if (coords_valid || frame_error) begin
                check("pulse_exclusive", 64'(coords_valid & frame_error), 64'd0);
                if (exp_q.size() == 0) begin
                    check("spurious_pulse", 64'({coords_valid, frame_error}), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_kind", 64'({coords_valid, frame_error}),
                          mon_e.is_err ? 64'd1 : 64'd2);
                    check("pulse_latency", 64'(cyc), 64'(mon_e.due));
                    if (mon_e.is_err) begin
                        check("sat_on_error", 64'(coords_sat), 64'd0);
                    end else begin
                        check("frame_coords", 64'(coords), 64'(mon_e.coords));
                        check("frame_sat", 64'(coords_sat), 64'(mon_e.sat));
                    end
                end
            end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
                mon_e = exp_q.pop_front();
                check("missing_pulse", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    // Drive a string one character at a time with a strobe-low gap (holding
    // 'S' on ascii) between characters; queue the expectation at index trig.
    task automatic send_frame(input string s, input int trig, input bit is_err,
                              input logic [29:0] co, input bit sat);
        exp_t e;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clock);
            ascii       = s[i];
            ascii_valid = 1'b1;
            if (i == trig) begin
                e.is_err = is_err;
                e.coords = co;
                e.sat    = sat;
                e.due    = cyc + 1;
                exp_q.push_back(e);
            end
            @(negedge clock);
            ascii_valid = 1'b0;
            ascii       = 8'h53;
        end
        @(negedge clock);
    endtask

    initial begin
        reset       = 1'b1;
        ascii       = 8'h00;
        ascii_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_coords", 64'(coords), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pulses", 64'({coords_valid, coords_sat, frame_error}), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("idle_gap_busy", 64'(busy), 64'd0);

        send_frame("xS12,345,7E", 10, 1'b0, pack3(12, 345, 7), 1'b0);

        send_frame("S1,2E", 4, 1'b1, '0, 1'b0);
        check("err_coords_held", 64'(coords), 64'(pack3(12, 345, 7)));
        check("err_busy_low", 64'(busy), 64'd0);

        send_frame("S 1\r,2\n,3 E", 10, 1'b0, pack3(1, 2, 3), 1'b0);

        send_frame("S1,,2,3E", 3, 1'b1, '0, 1'b0);
        send_frame("SE", 1, 1'b1, '0, 1'b0);
        send_frame("S1,2,3,E", 6, 1'b1, '0, 1'b0);
        send_frame("S1,2,3xE", 6, 1'b1, '0, 1'b0);
        check("errs_coords_held", 64'(coords), 64'(pack3(1, 2, 3)));

        send_frame("S9,2000,5E", 9, 1'b0, pack3(9, 1023, 5), 1'b1);
        send_frame("S12345,0,0E", 5, 1'b1, '0, 1'b0);
        check("digits_busy_low", 64'(busy), 64'd0);

        send_frame("S1,2S", 4, 1'b1, '0, 1'b0);
        check("restart_busy", 64'(busy), 64'd1);
        send_frame("3,4,5E", 5, 1'b0, pack3(3, 4, 5), 1'b0);

        send_frame("S12,", -1, 1'b0, '0, 1'b0);
        check("mid_frame_busy", 64'(busy), 64'd1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_coords", 64'(coords), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        send_frame("4,5E", -1, 1'b0, '0, 1'b0);
        check("post_rst_coords", 64'(coords), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);

`ifdef COORD_SIGN_EN
        send_frame("S-5,0,-512E", 10, 1'b0, pack3(32'h3FB, 0, 32'h200), 1'b0);
        send_frame("S-,1,2E", 2, 1'b1, '0, 1'b0);
        send_frame("S-600,600,1E", 11, 1'b0, pack3(32'h200, 32'h1FF, 1), 1'b1);
        check("signed_coords_held", 64'(coords), 64'(pack3(32'h200, 32'h1FF, 1)));
`else
        send_frame("S-5,0,-512E", 1, 1'b1, '0, 1'b0);
        check("minus_coords_held", 64'(coords), 64'd0);
`endif

        repeat (4) @(negedge clock);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
